// File: rtl/axi4_burst_mem_if.sv
// AXI4 bus bundle for axi4_burst_mem: AW/W/B/AR/R channels with master/slave modports.
interface axi4_burst_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     MEM_AWID;
  logic [ADDR_WIDTH-1:0]   MEM_AWADDR;
  logic [7:0]              MEM_AWLEN;
  logic [2:0]              MEM_AWSIZE;
  logic [1:0]              MEM_AWBURST;
  logic                    MEM_AWLOCK;
  logic [3:0]              MEM_AWCACHE;
  logic [2:0]              MEM_AWPROT;
  logic [3:0]              MEM_AWQOS;
  logic                    MEM_AWVALID, MEM_AWREADY;

  logic [DATA_WIDTH-1:0]   MEM_WDATA;
  logic [DATA_WIDTH/8-1:0] MEM_WSTRB;
  logic                    MEM_WLAST, MEM_WVALID, MEM_WREADY;

  logic [ID_WIDTH-1:0]     MEM_BID;
  logic [1:0]              MEM_BRESP;
  logic                    MEM_BVALID, MEM_BREADY;

  logic [ID_WIDTH-1:0]     MEM_ARID;
  logic [ADDR_WIDTH-1:0]   MEM_ARADDR;
  logic [7:0]              MEM_ARLEN;
  logic [2:0]              MEM_ARSIZE;
  logic [1:0]              MEM_ARBURST;
  logic                    MEM_ARLOCK;
  logic [3:0]              MEM_ARCACHE;
  logic [2:0]              MEM_ARPROT;
  logic [3:0]              MEM_ARQOS;
  logic                    MEM_ARVALID, MEM_ARREADY;

  logic [ID_WIDTH-1:0]     MEM_RID;
  logic [DATA_WIDTH-1:0]   MEM_RDATA;
  logic [1:0]              MEM_RRESP;
  logic                    MEM_RLAST, MEM_RVALID, MEM_RREADY;

  modport slave (
    input  MEM_AWID, MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST, MEM_AWLOCK,
           MEM_AWCACHE, MEM_AWPROT, MEM_AWQOS, MEM_AWVALID,
           MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID, MEM_BREADY,
           MEM_ARID, MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST, MEM_ARLOCK,
           MEM_ARCACHE, MEM_ARPROT, MEM_ARQOS, MEM_ARVALID, MEM_RREADY,
    output MEM_AWREADY, MEM_WREADY, MEM_BID, MEM_BRESP, MEM_BVALID, MEM_ARREADY,
           MEM_RID, MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_RVALID
  );

  modport master (
    output MEM_AWID, MEM_AWADDR, MEM_AWLEN, MEM_AWSIZE, MEM_AWBURST, MEM_AWLOCK,
           MEM_AWCACHE, MEM_AWPROT, MEM_AWQOS, MEM_AWVALID,
           MEM_WDATA, MEM_WSTRB, MEM_WLAST, MEM_WVALID, MEM_BREADY,
           MEM_ARID, MEM_ARADDR, MEM_ARLEN, MEM_ARSIZE, MEM_ARBURST, MEM_ARLOCK,
           MEM_ARCACHE, MEM_ARPROT, MEM_ARQOS, MEM_ARVALID, MEM_RREADY,
    input  MEM_AWREADY, MEM_WREADY, MEM_BID, MEM_BRESP, MEM_BVALID, MEM_ARREADY,
           MEM_RID, MEM_RDATA, MEM_RRESP, MEM_RLAST, MEM_RVALID
  );
endinterface

// File: rtl/axi4_burst_mem.sv
// AXI4 burst slave RAM: FIXED/INCR (+WRAP when AXI_MEM_WRAP_EN is defined), byte strobes,
// one outstanding write and one outstanding read on independent FSMs, SLVERR on bad beats.

// Per-beat address decode shared by both channels: error flag, word index, next address.
module axi4_burst_mem_beat #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [7:0]                 len,
  input  logic [2:0]                 size,
  input  logic [1:0]                 burst,
  output logic                       err,
  output logic [$clog2(DEPTH)-1:0]   idx,
  output logic [ADDR_WIDTH-1:0]      addr_nxt
);
  localparam int BYTES = DATA_WIDTH/8;
  localparam int LOG2  = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam int unsigned SPAN_I = DEPTH * BYTES;
  localparam logic [ADDR_WIDTH:0] SPAN = AW1'(SPAN_I);

  logic [ADDR_WIDTH:0]   off;
  logic [ADDR_WIDTH-1:0] incr;
  logic                  bad_burst;

  // Extra MSB catches addresses below the window as a borrow.
  assign off  = {1'b0, addr} - {1'b0, START_ADDR};
  assign incr = ADDR_WIDTH'(1) << size;
  assign idx  = IDX_W'(off >> LOG2);
  assign err  = off[ADDR_WIDTH] || (off >= SPAN) || (int'(size) > LOG2) || bad_burst;

`ifdef AXI_MEM_WRAP_EN
  logic [ADDR_WIDTH-1:0] wmask;
  assign wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
  assign bad_burst = (burst == 2'b11) ||
    (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  always_comb begin
    addr_nxt = addr;
    case (burst)
      2'b01:   addr_nxt = addr + incr;
      2'b10:   addr_nxt = (addr & ~wmask) | ((addr + incr) & wmask);
      default: addr_nxt = addr;
    endcase
  end
`else
  logic len_unused;
  assign len_unused = ^len;
  assign bad_burst  = burst[1];
  assign addr_nxt   = (burst == 2'b01) ? addr + incr : addr;
`endif
endmodule

module axi4_burst_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input logic ACLK,
  input logic ARESETn,
  axi4_burst_mem_if.slave bus
);
  localparam int BYTES = DATA_WIDTH/8;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id, bid;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_nxt;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst, bresp;
  logic                  w_err, w_beat_err, w_bad, awready, wready, bvalid;
  logic [IDX_W-1:0]      w_idx;

  r_state_t r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id, rid;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst, rresp;
  logic                  r_err, arready, rvalid, rlast;
  logic [DATA_WIDTH-1:0] rdata;
  logic [IDX_W-1:0]      r_idx;

  logic aw_fire, w_fire, w_last, ar_fire, r_fire, r_load;
  logic ign_unused;
  assign ign_unused = ^{bus.MEM_AWLOCK, bus.MEM_AWCACHE, bus.MEM_AWPROT, bus.MEM_AWQOS,
                        bus.MEM_ARLOCK, bus.MEM_ARCACHE, bus.MEM_ARPROT, bus.MEM_ARQOS};

  axi4_burst_mem_beat #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH),
    .START_ADDR(START_ADDR)) u_wbeat (.addr(w_addr), .len(w_len), .size(w_size),
    .burst(w_burst), .err(w_beat_err), .idx(w_idx), .addr_nxt(w_addr_nxt));
  axi4_burst_mem_beat #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH),
    .START_ADDR(START_ADDR)) u_rbeat (.addr(r_addr), .len(r_len), .size(r_size),
    .burst(r_burst), .err(r_err), .idx(r_idx), .addr_nxt(r_addr_nxt));

  assign aw_fire = awready && bus.MEM_AWVALID;
  assign w_fire  = wready && bus.MEM_WVALID;
  assign w_last  = (w_cnt == w_len);
  // A WLAST that disagrees with the beat count poisons only that beat.
  assign w_bad   = w_beat_err || (bus.MEM_WLAST != w_last);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_next = W_DATA;
      W_DATA:  if (w_fire && w_last) w_next = W_RESP;
      W_RESP:  if (bvalid && bus.MEM_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
      bid <= '0; bresp <= '0;
      w_id <= '0; w_addr <= '0; w_len <= '0; w_size <= '0; w_burst <= '0;
      w_cnt <= '0; w_err <= 1'b0;
    end else begin
      w_state <= w_next;
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA);
      bvalid  <= (w_next == W_RESP);
      if (aw_fire) begin
        w_id <= bus.MEM_AWID; w_addr <= bus.MEM_AWADDR; w_len <= bus.MEM_AWLEN;
        w_size <= bus.MEM_AWSIZE; w_burst <= bus.MEM_AWBURST;
        w_cnt <= '0; w_err <= 1'b0;
      end
      if (w_fire) begin
        w_addr <= w_addr_nxt;
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err || w_bad;
        if (w_last) begin
          bid   <= w_id;
          bresp <= (w_err || w_bad) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_fire && !w_bad)
      for (int b = 0; b < BYTES; b++)
        if (bus.MEM_WSTRB[b]) mem[w_idx][b*8 +: 8] <= bus.MEM_WDATA[b*8 +: 8];
  end

  assign ar_fire = arready && bus.MEM_ARVALID;
  assign r_fire  = rvalid && bus.MEM_RREADY;
  // Fetch the next beat when the output slot is empty or is being drained mid-burst.
  assign r_load  = (r_state == R_DATA) && (!rvalid || (r_fire && !rlast));

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_DATA;
      R_DATA:  if (r_fire && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      arready <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0;
      rid <= '0; rresp <= '0; rdata <= '0;
      r_id <= '0; r_addr <= '0; r_len <= '0; r_size <= '0; r_burst <= '0; r_cnt <= '0;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      if (ar_fire) begin
        r_id <= bus.MEM_ARID; r_addr <= bus.MEM_ARADDR; r_len <= bus.MEM_ARLEN;
        r_size <= bus.MEM_ARSIZE; r_burst <= bus.MEM_ARBURST; r_cnt <= '0;
      end
      if (r_load) begin
        rvalid <= 1'b1;
        rid    <= r_id;
        rresp  <= r_err ? 2'b10 : 2'b00;
        rdata  <= r_err ? '0 : mem[r_idx];
        rlast  <= (r_cnt == r_len);
        r_addr <= r_addr_nxt;
        r_cnt  <= r_cnt + 8'd1;
      end else if (r_fire) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end
  end

  assign bus.MEM_AWREADY = awready;
  assign bus.MEM_WREADY  = wready;
  assign bus.MEM_BVALID  = bvalid;
  assign bus.MEM_BID     = bid;
  assign bus.MEM_BRESP   = bresp;
  assign bus.MEM_ARREADY = arready;
  assign bus.MEM_RVALID  = rvalid;
  assign bus.MEM_RID     = rid;
  assign bus.MEM_RDATA   = rdata;
  assign bus.MEM_RRESP   = rresp;
  assign bus.MEM_RLAST   = rlast;
endmodule

// File: tb/tb_axi4_burst_mem.sv
// Directed bench for axi4_burst_mem: single, INCR, WRAP, strobes, errors, backpressure, reset.
module tb_axi4_burst_mem;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi4_burst_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) bus();

  axi4_burst_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .DEPTH(1024),
    .START_ADDR(32'h0)) dut (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));

  int checks = 0, failures = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [15:0] wl;
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [3:0]  rid_cap, bid_cap;
  logic [1:0]  bresp_cap;
  int nbeat, rlat, gaps;

  task automatic init_bus();
    bus.MEM_AWID = '0; bus.MEM_AWADDR = '0; bus.MEM_AWLEN = '0; bus.MEM_AWSIZE = 3'd2;
    bus.MEM_AWBURST = 2'b01; bus.MEM_AWLOCK = 1'b0; bus.MEM_AWCACHE = '0;
    bus.MEM_AWPROT = '0; bus.MEM_AWQOS = '0; bus.MEM_AWVALID = 1'b0;
    bus.MEM_WDATA = '0; bus.MEM_WSTRB = '0; bus.MEM_WLAST = 1'b0; bus.MEM_WVALID = 1'b0;
    bus.MEM_BREADY = 1'b0;
    bus.MEM_ARID = '0; bus.MEM_ARADDR = '0; bus.MEM_ARLEN = '0; bus.MEM_ARSIZE = 3'd2;
    bus.MEM_ARBURST = 2'b01; bus.MEM_ARLOCK = 1'b0; bus.MEM_ARCACHE = '0;
    bus.MEM_ARPROT = '0; bus.MEM_ARQOS = '0; bus.MEM_ARVALID = 1'b0;
    bus.MEM_RREADY = 1'b0;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bus.MEM_AWID = id; bus.MEM_AWADDR = addr; bus.MEM_AWLEN = len;
    bus.MEM_AWSIZE = size; bus.MEM_AWBURST = burst; bus.MEM_AWVALID = 1'b1;
    for (int i = 0; i < 100 && !bus.MEM_AWREADY; i++) @(negedge ACLK);
    checks++;
    if (!bus.MEM_AWREADY) begin failures++; $display("FAIL aw_timeout: AWREADY=%b required 1", bus.MEM_AWREADY); end
    @(negedge ACLK);
    bus.MEM_AWVALID = 1'b0;
  endtask

  task automatic do_wbeats(input int n);
    for (int i = 0; i < n; i++) begin
      bus.MEM_WDATA = wd[i]; bus.MEM_WSTRB = ws[i]; bus.MEM_WLAST = wl[i];
      bus.MEM_WVALID = 1'b1;
      for (int t = 0; t < 100 && !bus.MEM_WREADY; t++) @(negedge ACLK);
      if (!bus.MEM_WREADY) begin
        checks++; failures++; $display("FAIL w_timeout: WREADY=0 required 1 at beat %0d", i);
      end
      @(negedge ACLK);
    end
    bus.MEM_WVALID = 1'b0; bus.MEM_WLAST = 1'b0;
  endtask

  task automatic do_b();
    bus.MEM_BREADY = 1'b1;
    for (int t = 0; t < 100 && !bus.MEM_BVALID; t++) @(negedge ACLK);
    if (!bus.MEM_BVALID) begin
      checks++; failures++; $display("FAIL b_timeout: BVALID=0 required 1");
    end
    bid_cap = bus.MEM_BID; bresp_cap = bus.MEM_BRESP;
    @(negedge ACLK);
    bus.MEM_BREADY = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    do_aw(id, addr, len, size, burst);
    do_wbeats(int'(len) + 1);
    do_b();
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    bus.MEM_ARID = id; bus.MEM_ARADDR = addr; bus.MEM_ARLEN = len;
    bus.MEM_ARSIZE = 3'd2; bus.MEM_ARBURST = burst; bus.MEM_ARVALID = 1'b1;
    for (int i = 0; i < 100 && !bus.MEM_ARREADY; i++) @(negedge ACLK);
    checks++;
    if (!bus.MEM_ARREADY) begin failures++; $display("FAIL ar_timeout: ARREADY=%b required 1", bus.MEM_ARREADY); end
    @(negedge ACLK);
    bus.MEM_ARVALID = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int guard;
    bit done;
    bus.MEM_RREADY = 1'b1;
    do_ar(id, addr, len, burst);
    nbeat = 0; rlat = 0; guard = 0; done = 0;
    while (!done && guard < 400) begin
      if (bus.MEM_RVALID) begin
        if (nbeat < 16) begin
          rd[nbeat] = bus.MEM_RDATA; rr[nbeat] = bus.MEM_RRESP; rl[nbeat] = bus.MEM_RLAST;
        end
        rid_cap = bus.MEM_RID;
        nbeat++;
        if (bus.MEM_RLAST) done = 1;
      end else if (nbeat == 0) rlat++;
      guard++;
      @(negedge ACLK);
    end
    gaps = guard - rlat - nbeat;
    bus.MEM_RREADY = 1'b0;
    if (!done) begin checks++; failures++; $display("FAIL r_timeout: RLAST never seen, beats=%0d", nbeat); end
  endtask

  task automatic test_reset();
    init_bus();
    repeat (3) @(negedge ACLK);
    checks++;
    if ({bus.MEM_AWREADY, bus.MEM_WREADY, bus.MEM_BVALID, bus.MEM_ARREADY, bus.MEM_RVALID, bus.MEM_RLAST} !== 6'b0) begin
      failures++; $display("FAIL reset_ctl: got %b required 000000",
        {bus.MEM_AWREADY, bus.MEM_WREADY, bus.MEM_BVALID, bus.MEM_ARREADY, bus.MEM_RVALID, bus.MEM_RLAST});
    end
    checks++;
    if ({bus.MEM_BID, bus.MEM_BRESP, bus.MEM_RID, bus.MEM_RRESP, bus.MEM_RDATA} !== 44'h0) begin
      failures++; $display("FAIL reset_data: BID=%h BRESP=%h RID=%h RRESP=%h RDATA=%h required all 0",
        bus.MEM_BID, bus.MEM_BRESP, bus.MEM_RID, bus.MEM_RRESP, bus.MEM_RDATA);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if (bus.MEM_AWREADY !== 1'b1 || bus.MEM_ARREADY !== 1'b1) begin
      failures++; $display("FAIL reset_release: AWREADY=%b ARREADY=%b required 1 1", bus.MEM_AWREADY, bus.MEM_ARREADY);
    end
  endtask

  task automatic test_single();
    wd[0] = 32'hABCD0123; ws[0] = 4'hF; wl = 16'h1;
    do_write(4'h5, 32'h4, 8'd0, 3'd2, 2'b01);
    checks++;
    if (bresp_cap !== 2'b00 || bid_cap !== 4'h5) begin
      failures++; $display("FAIL single_b: BRESP=%b BID=%h required 00 5", bresp_cap, bid_cap);
    end
    do_read(4'h6, 32'h4, 8'd0, 2'b01);
    checks++;
    if (nbeat !== 1 || rd[0] !== 32'hABCD0123 || rr[0] !== 2'b00 || rl[0] !== 1'b1 || rid_cap !== 4'h6) begin
      failures++; $display("FAIL single_r: beats=%0d RDATA=%h RRESP=%b RLAST=%b RID=%h required 1 abcd0123 00 1 6",
        nbeat, rd[0], rr[0], rl[0], rid_cap);
    end
    checks++;
    if (rlat !== 1) begin failures++; $display("FAIL read_latency: idle cycles=%0d required 1", rlat); end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    wl = 16'h8;
    do_write(4'h1, 32'h10, 8'd3, 3'd2, 2'b01);
    checks++;
    if (bresp_cap !== 2'b00) begin failures++; $display("FAIL incr_b: BRESP=%b required 00", bresp_cap); end
    do_read(4'h2, 32'h10, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd[i] !== 32'(i + 1) || rl[i] !== (i == 3) || rr[i] !== 2'b00) begin
        failures++; $display("FAIL incr_r%0d: RDATA=%h RLAST=%b RRESP=%b required %h %b 00",
          i, rd[i], rl[i], rr[i], 32'(i + 1), (i == 3));
      end
    end
    checks++;
    if (gaps !== 0 || nbeat !== 4) begin
      failures++; $display("FAIL back_to_back: gaps=%0d beats=%0d required 0 4", gaps, nbeat);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e_incr [4];
    logic [31:0] e_wrap [4];
    logic [1:0]  e_bresp, e_rresp;
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    wl = 16'h8;
`ifdef AXI_MEM_WRAP_EN
    e_incr = '{32'hC, 32'hD, 32'hA, 32'hB};
    e_wrap = '{32'hA, 32'hB, 32'hC, 32'hD};
    e_bresp = 2'b00; e_rresp = 2'b00;
`else
    e_incr = '{32'h1, 32'h2, 32'h3, 32'h4};
    e_wrap = '{32'h0, 32'h0, 32'h0, 32'h0};
    e_bresp = 2'b10; e_rresp = 2'b10;
`endif
    do_write(4'h3, 32'h18, 8'd3, 3'd2, 2'b10);
    checks++;
    if (bresp_cap !== e_bresp) begin failures++; $display("FAIL wrap_b: BRESP=%b required %b", bresp_cap, e_bresp); end
    do_read(4'h3, 32'h10, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd[i] !== e_incr[i]) begin failures++; $display("FAIL wrap_mem%0d: RDATA=%h required %h", i, rd[i], e_incr[i]); end
    end
    do_read(4'h3, 32'h18, 8'd3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd[i] !== e_wrap[i] || rr[i] !== e_rresp) begin
        failures++; $display("FAIL wrap_rd%0d: RDATA=%h RRESP=%b required %h %b", i, rd[i], rr[i], e_wrap[i], e_rresp);
      end
    end
  endtask

  task automatic test_strobe();
    wd[0] = 32'h11223344; ws[0] = 4'hF; wl = 16'h1;
    do_write(4'h0, 32'h20, 8'd0, 3'd2, 2'b01);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0011;
    do_write(4'h0, 32'h20, 8'd0, 3'd2, 2'b01);
    do_read(4'h0, 32'h20, 8'd0, 2'b01);
    checks++;
    if (rd[0] !== 32'h1122CCDD) begin failures++; $display("FAIL strobe: RDATA=%h required 1122ccdd", rd[0]); end
  endtask

  task automatic test_errors();
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl = 16'h1;
    do_write(4'h7, 32'h1000, 8'd0, 3'd2, 2'b01);
    checks++;
    if (bresp_cap !== 2'b10) begin failures++; $display("FAIL oob_write: BRESP=%b required 10", bresp_cap); end
    do_write(4'h7, 32'h40, 8'd0, 3'd3, 2'b01);
    checks++;
    if (bresp_cap !== 2'b10) begin failures++; $display("FAIL size_err: BRESP=%b required 10", bresp_cap); end
    wd[0] = 32'h5A5A0FFC;
    do_write(4'h7, 32'hFFC, 8'd0, 3'd2, 2'b01);
    do_read(4'h8, 32'hFFC, 8'd1, 2'b01);
    checks++;
    if (rd[0] !== 32'h5A5A0FFC || rr[0] !== 2'b00 || rl[0] !== 1'b0) begin
      failures++; $display("FAIL edge_beat0: RDATA=%h RRESP=%b RLAST=%b required 5a5a0ffc 00 0", rd[0], rr[0], rl[0]);
    end
    checks++;
    if (rd[1] !== 32'h0 || rr[1] !== 2'b10 || rl[1] !== 1'b1) begin
      failures++; $display("FAIL edge_beat1: RDATA=%h RRESP=%b RLAST=%b required 0 10 1", rd[1], rr[1], rl[1]);
    end
    wd[0] = 32'h7; wd[1] = 32'h8; wd[2] = 32'h9;
    for (int i = 0; i < 3; i++) ws[i] = 4'hF;
    wl = 16'h4;
    do_write(4'h9, 32'h30, 8'd2, 3'd2, 2'b01);
    wd[0] = 32'h70; wd[1] = 32'h80; wd[2] = 32'h90; wl = 16'h6;
    do_write(4'h9, 32'h30, 8'd2, 3'd2, 2'b01);
    checks++;
    if (bresp_cap !== 2'b10) begin failures++; $display("FAIL early_wlast: BRESP=%b required 10", bresp_cap); end
    do_read(4'h9, 32'h30, 8'd2, 2'b01);
    checks++;
    if (rd[0] !== 32'h70 || rd[1] !== 32'h8 || rd[2] !== 32'h90) begin
      failures++; $display("FAIL err_beat_skip: RDATA=%h %h %h required 70 8 90", rd[0], rd[1], rd[2]);
    end
    wd[0] = 32'h1234; wl = 16'h0;
    do_write(4'h9, 32'h44, 8'd0, 3'd2, 2'b01);
    checks++;
    if (bresp_cap !== 2'b10) begin failures++; $display("FAIL missing_wlast: BRESP=%b required 10", bresp_cap); end
    do_read(4'h9, 32'h10, 8'd0, 2'b11);
    checks++;
    if (rr[0] !== 2'b10 || rd[0] !== 32'h0) begin
      failures++; $display("FAIL burst_rsvd: RRESP=%b RDATA=%h required 10 0", rr[0], rd[0]);
    end
  endtask

  task automatic test_backpressure();
    wd[0] = 32'h00C0FFEE; ws[0] = 4'hF; wl = 16'h1;
    do_aw(4'hC, 32'h48, 8'd0, 3'd2, 2'b01);
    do_wbeats(1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.MEM_BVALID !== 1'b1 || bus.MEM_BID !== 4'hC || bus.MEM_BRESP !== 2'b00 || bus.MEM_AWREADY !== 1'b0) begin
        failures++; $display("FAIL b_hold%0d: BVALID=%b BID=%h BRESP=%b AWREADY=%b required 1 c 00 0",
          i, bus.MEM_BVALID, bus.MEM_BID, bus.MEM_BRESP, bus.MEM_AWREADY);
      end
      @(negedge ACLK);
    end
    do_b();
    checks++;
    if (bus.MEM_AWREADY !== 1'b1) begin failures++; $display("FAIL b_release: AWREADY=%b required 1", bus.MEM_AWREADY); end
    bus.MEM_RREADY = 1'b0;
    do_ar(4'hD, 32'h30, 8'd2, 2'b01);
    for (int t = 0; t < 100 && !bus.MEM_RVALID; t++) @(negedge ACLK);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.MEM_RVALID !== 1'b1 || bus.MEM_RDATA !== 32'h70 || bus.MEM_RLAST !== 1'b0 || bus.MEM_RID !== 4'hD) begin
        failures++; $display("FAIL r_hold%0d: RVALID=%b RDATA=%h RLAST=%b RID=%h required 1 70 0 d",
          i, bus.MEM_RVALID, bus.MEM_RDATA, bus.MEM_RLAST, bus.MEM_RID);
      end
      @(negedge ACLK);
    end
    bus.MEM_RREADY = 1'b1;
    @(negedge ACLK);
    checks++;
    if (bus.MEM_RDATA !== 32'h8 || bus.MEM_RLAST !== 1'b0) begin
      failures++; $display("FAIL r_resume1: RDATA=%h RLAST=%b required 8 0", bus.MEM_RDATA, bus.MEM_RLAST);
    end
    @(negedge ACLK);
    checks++;
    if (bus.MEM_RDATA !== 32'h90 || bus.MEM_RLAST !== 1'b1) begin
      failures++; $display("FAIL r_resume2: RDATA=%h RLAST=%b required 90 1", bus.MEM_RDATA, bus.MEM_RLAST);
    end
    @(negedge ACLK);
    bus.MEM_RREADY = 1'b0;
    checks++;
    if (bus.MEM_RVALID !== 1'b0 || bus.MEM_ARREADY !== 1'b1) begin
      failures++; $display("FAIL r_done: RVALID=%b ARREADY=%b required 0 1", bus.MEM_RVALID, bus.MEM_ARREADY);
    end
  endtask

  task automatic test_reset_mid();
    bus.MEM_RREADY = 1'b1;
    do_ar(4'hE, 32'h10, 8'd3, 2'b01);
    for (int t = 0; t < 100 && !bus.MEM_RVALID; t++) @(negedge ACLK);
    @(negedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if (bus.MEM_RVALID !== 1'b0 || bus.MEM_ARREADY !== 1'b0 || bus.MEM_RDATA !== 32'h0) begin
      failures++; $display("FAIL reset_mid: RVALID=%b ARREADY=%b RDATA=%h required 0 0 0",
        bus.MEM_RVALID, bus.MEM_ARREADY, bus.MEM_RDATA);
    end
    @(negedge ACLK);
    bus.MEM_RREADY = 1'b0;
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if (bus.MEM_ARREADY !== 1'b1) begin failures++; $display("FAIL reset_mid_release: ARREADY=%b required 1", bus.MEM_ARREADY); end
    do_read(4'h0, 32'h20, 8'd0, 2'b01);
    checks++;
    if (rd[0] !== 32'h1122CCDD) begin failures++; $display("FAIL mem_retained: RDATA=%h required 1122ccdd", rd[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_wrap();
    test_strobe();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
